regfile_wb: RTL
===============

REGFILE_WB -- requirements
Module: regfile_wb

Interface
REQ-001 Parameter XLEN, default 32, data width of register writeback.
REQ-002 Parameter FIFO_DEPTH, default 2, entries in long-latency return buffer (power of 2, >=2).
REQ-003 clk_sys  in  1  single system clock; all state on rising edge.
REQ-004 rst_sys  in  1  reset, asynchronous, active-low.
REQ-005 i_pip_flush  in  1  pipeline flush; cancels same-cycle ALU writeback and issue marking.
REQ-006 alu_valid / alu_rd_idx / alu_data  in  1/5/XLEN  single-cycle ALU result, always accepted.
REQ-007 lsu_valid / lsu_rd_idx / lsu_data  in  1/5/XLEN  long-latency (load/mul/div) result.
REQ-008 lsu_ready  out  1  buffer can accept an LSU result this cycle.
REQ-009 iss_valid / iss_rd_idx / iss_long  in  1/1/5... iss_rd_idx 5 bits; issue of long-latency op marks rd busy.
REQ-010 rs1_idx / rs2_idx  in  5/5  hazard query indices.
REQ-011 rs1_busy / rs2_busy  out  1/1  queried register awaits a long-latency result.
REQ-012 rd_we / rd_idx / rd_data  out  1/5/XLEN  registered single write port into the register file.

Function
REQ-013 LSU transfer SHALL occur when lsu_valid && lsu_ready; lsu_ready SHALL equal (buffer count < FIFO_DEPTH), independent of lsu_valid.
REQ-014 Each cycle the write-port register SHALL load the ALU result if alu_valid && !i_pip_flush, else the buffer head if buffer non-empty, else rd_we=0.
REQ-015 Write-port latency SHALL be one cycle from ALU input; >=2 cycles from LSU transfer (enqueue then dequeue).
REQ-016 Buffered LSU results SHALL commit in arrival order; i_pip_flush SHALL NOT discard buffered or incoming LSU results.
REQ-017 Any source with rd_idx==0 SHALL be dropped: never rd_we=1 for x0, LSU x0 transfer still consumes handshake but not buffer space.
REQ-018 Buffer SHALL support simultaneous enqueue and dequeue when full (count unchanged, lsu_ready stays 0 that cycle per REQ-013).
REQ-019 Scoreboard: 32 bits, bit 0 hard-wired 0; iss_valid && iss_long && !i_pip_flush && iss_rd_idx!=0 SHALL set bit iss_rd_idx.
REQ-020 Bit SHALL clear on the edge where the matching buffer entry is loaded into the write-port register.
REQ-021 Simultaneous set and clear of same index SHALL leave bit set.
REQ-022 rsN_busy SHALL be combinational scoreboard[rsN_idx]; busy drop coincides with rd_we, covered by register-file write bypass.
REQ-023 ALU and buffer contention: ALU wins; buffer head waits, no loss, no reorder.

Reset
REQ-024 On rst_sys low: rd_we=0, rd_idx=0, rd_data=0, buffer empty (lsu_ready=1), scoreboard all 0, busy outputs 0.
REQ-025 Reset mid-operation SHALL discard buffered results; first cycle after release behaves as idle.

Structure
REQ-026 XLEN, REG_IDX_W=5, FIFO_DEPTH default SHALL reside in shared package core_pkg.
REQ-027 Buffer SHALL be sub-module wb_fifo (valid/ready in, pop out, count, registered storage).
REQ-028 Scoreboard, arbitration and write-port register SHALL reside in regfile_wb.

Verification
REQ-029 alu_valid=1, alu_rd_idx=5, alu_data=0x1234 -> next cycle rd_we=1, rd_idx=5, rd_data=0x1234.
REQ-030 iss long rd=7; later lsu result rd=7 data=0xCAFE with ALU idle -> rs1_busy(7)=1 until rd_we for x7, same cycle busy=0.
REQ-031 Continuous ALU writes while three LSU results arrive -> lsu_ready=0 after 2 buffered; all three commit in order once ALU idle.
REQ-032 alu_rd_idx=0 and lsu_rd_idx=0 -> rd_we never 1, buffer count stays 0.
REQ-033 i_pip_flush with alu_valid=1 and iss_long=1 -> no write, no busy set; buffered LSU entry still commits.
REQ-034 Assert rst_sys with 2 buffered entries and busy bits set -> outputs zero, lsu_ready=1, no stale commit after release.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core widths and helpers for the register-file writeback path.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int NUM_REGS   = 32;
    localparam int FIFO_DEPTH = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // One-hot vector selecting a single architectural register.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
        logic [NUM_REGS-1:0] vec;
        vec      = {NUM_REGS{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Bundle of ALU/LSU result, issue, hazard-query and write-port signals.
interface regfile_wb_if #(
    parameter int XLEN = core_pkg::XLEN
);
    import core_pkg::*;

    logic            i_pip_flush;
    logic            alu_valid;
    reg_idx_t        alu_rd_idx;
    logic [XLEN-1:0] alu_data;
    logic            lsu_valid;
    reg_idx_t        lsu_rd_idx;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            iss_valid;
    reg_idx_t        iss_rd_idx;
    logic            iss_long;
    reg_idx_t        rs1_idx;
    reg_idx_t        rs2_idx;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            rd_we;
    reg_idx_t        rd_idx;
    logic [XLEN-1:0] rd_data;

    modport slave (
        input  i_pip_flush, alu_valid, alu_rd_idx, alu_data,
        input  lsu_valid, lsu_rd_idx, lsu_data,
        input  iss_valid, iss_rd_idx, iss_long, rs1_idx, rs2_idx,
        output lsu_ready, rs1_busy, rs2_busy, rd_we, rd_idx, rd_data
    );

    modport master (
        output i_pip_flush, alu_valid, alu_rd_idx, alu_data,
        output lsu_valid, lsu_rd_idx, lsu_data,
        output iss_valid, iss_rd_idx, iss_long, rs1_idx, rs2_idx,
        input  lsu_ready, rs1_busy, rs2_busy, rd_we, rd_idx, rd_data
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order return buffer for long-latency results; head is read straight from
// registered storage so the caller can decide whether to pop this cycle.
module wb_fifo
    import core_pkg::*;
#(
    parameter  int DATA_W = XLEN,
    parameter  int DEPTH  = FIFO_DEPTH,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  reg_idx_t          push_idx,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_valid,
    output reg_idx_t          head_idx,
    output logic [DATA_W-1:0] head_data,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    reg_idx_t          idx_mem_q  [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic              push_s;
    logic              pop_s;

    // Handshake, pointer and occupancy next-state.
    always_comb begin
        push_ready = (count_q < DEPTH_C);
        head_valid = (count_q != {CNT_W{1'b0}});
        push_s     = push_valid && push_ready;
        pop_s      = pop && head_valid;
        wr_ptr_d   = push_s ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents only meaningful while counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            idx_mem_q[wr_ptr_q]  <= push_idx;
            data_mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_idx  = idx_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/regfile_wb.sv
// Register-file writeback: arbitrates ALU and buffered long-latency results onto
// one registered write port and tracks registers awaiting long-latency data.
module regfile_wb #(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int FIFO_DEPTH = core_pkg::FIFO_DEPTH
) (
    input  logic         clk_sys,
    input  logic         rst_sys,
    regfile_wb_if.slave  bus
);
    import core_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic            alu_take_s;
    logic            lsu_push_s;
    logic            pop_s;
    logic            head_valid_s;
    logic            fifo_ready_s;
    reg_idx_t        head_idx_s;
    logic [XLEN-1:0] head_data_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [NUM_REGS-1:0] sb_set_s;
    logic [NUM_REGS-1:0] sb_clr_s;

    logic            rd_we_q, rd_we_d;
    reg_idx_t        rd_idx_q, rd_idx_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] sb_q, sb_d;

    // x0 results never enter the buffer but still complete the handshake.
    assign lsu_push_s = bus.lsu_valid && (bus.lsu_rd_idx != 5'd0);

    wb_fifo #(
        .DATA_W (XLEN),
        .DEPTH  (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk        (clk_sys),
        .rst_n      (rst_sys),
        .push_valid (lsu_push_s),
        .push_ready (fifo_ready_s),
        .push_idx   (bus.lsu_rd_idx),
        .push_data  (bus.lsu_data),
        .pop        (pop_s),
        .head_valid (head_valid_s),
        .head_idx   (head_idx_s),
        .head_data  (head_data_s),
        .count      (fifo_count_s)
    );

    // Write-port arbitration: a live ALU result wins, the buffer head waits.
    always_comb begin
        alu_take_s = bus.alu_valid && !bus.i_pip_flush && (bus.alu_rd_idx != 5'd0);
        pop_s      = 1'b0;
        rd_we_d    = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;
        if (alu_take_s) begin
            rd_we_d   = 1'b1;
            rd_idx_d  = bus.alu_rd_idx;
            rd_data_d = bus.alu_data;
        end else if (head_valid_s && (fifo_count_s != {CNT_W{1'b0}})) begin
            pop_s     = 1'b1;
            rd_we_d   = 1'b1;
            rd_idx_d  = head_idx_s;
            rd_data_d = head_data_s;
        end else begin
            rd_we_d   = 1'b0;
        end
    end

    // Busy scoreboard next-state; a same-cycle set overrides the clear.
    always_comb begin
        if (bus.iss_valid && bus.iss_long && !bus.i_pip_flush && (bus.iss_rd_idx != 5'd0)) begin
            sb_set_s = idx_onehot(bus.iss_rd_idx);
        end else begin
            sb_set_s = {NUM_REGS{1'b0}};
        end
        if (pop_s) begin
            sb_clr_s = idx_onehot(head_idx_s);
        end else begin
            sb_clr_s = {NUM_REGS{1'b0}};
        end
        sb_d    = (sb_q & ~sb_clr_s) | sb_set_s;
        sb_d[0] = 1'b0;
    end

    // Write-port register and scoreboard state.
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            rd_we_q   <= 1'b0;
            rd_idx_q  <= 5'd0;
            rd_data_q <= {XLEN{1'b0}};
            sb_q      <= {NUM_REGS{1'b0}};
        end else begin
            rd_we_q   <= rd_we_d;
            rd_idx_q  <= rd_idx_d;
            rd_data_q <= rd_data_d;
            sb_q      <= sb_d;
        end
    end

    assign bus.lsu_ready = fifo_ready_s;
    assign bus.rs1_busy  = sb_q[bus.rs1_idx];
    assign bus.rs2_busy  = sb_q[bus.rs2_idx];
    assign bus.rd_we     = rd_we_q;
    assign bus.rd_idx    = rd_idx_q;
    assign bus.rd_data   = rd_data_q;

endmodule
